// File: rtl/vga_host_regs_if.sv
// Host register port of vga_example: 8-bit bus, 3-bit address, read data, irq.
// master = host side (drives address/write/write_data); slave = register block.
interface vga_host_regs_if;
  logic [2:0] address;
  logic       write;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       irq;

  modport master (
    output address,
    output write,
    output write_data,
    input  read_data,
    input  irq
  );

  modport slave (
    input  address,
    input  write,
    input  write_data,
    output read_data,
    output irq
  );
endinterface

// File: rtl/vga_host_regs.sv
// Host register block for the line engine: shadow coords, GO/BUSY, beam, mode,
// PRNG, vblank irq.
// Ports: pclk, rst_n (sync, low); host (slave: address/write/write_data ->
// read_data/irq); vblnk, draw_done in; draw_go, cmd_sta/end_x/y, cmd_beam,
// cmd_mode out.
module vga_host_regs #(
  parameter logic [7:0] PRNG_SEED = 8'h01,
  parameter int         BEAM_W    = 4
) (
  input  logic              pclk,
  input  logic              rst_n,
  vga_host_regs_if.slave    host,
  input  logic              vblnk,
  input  logic              draw_done,
  output logic              draw_go,
  output logic [7:0]        cmd_sta_x,
  output logic [7:0]        cmd_sta_y,
  output logic [7:0]        cmd_end_x,
  output logic [7:0]        cmd_end_y,
  output logic [BEAM_W-1:0] cmd_beam,
  output logic [1:0]        cmd_mode
);

  localparam logic [2:0] A_STAX = 3'd0;
  localparam logic [2:0] A_STAY = 3'd1;
  localparam logic [2:0] A_ENDX = 3'd2;
  localparam logic [2:0] A_ENDY = 3'd3;
  localparam logic [2:0] A_BUSY = 3'd4;
  localparam logic [2:0] A_BEAM = 3'd5;
  localparam logic [2:0] A_MODE = 3'd6;
  localparam logic [2:0] A_PRNG = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [7:0] sta_x;
  logic [7:0] sta_y;
  logic [7:0] end_x;
  logic [7:0] end_y;
  logic [7:0] prng;
  logic [7:0] prng_nx;
  logic [7:0] rd_mux;
  logic       vblnk_q;
  logic       busy;
  logic       go_wr;
  logic       prng_wr;
  logic       launch;

  assign go_wr = host.write
              && (host.address == A_BUSY)
              && host.write_data[0];

  assign prng_wr = host.write
                && (host.address == A_PRNG);

  // taps 8,6,5,4 -> bits 7,5,4,3
  assign prng_nx = {prng[6:0], ^(prng & 8'hB8)};

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // GO is only honoured from IDLE; draw_done only from BUSY
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (go_wr) state_nx = LAUNCH;
      end
      LAUNCH: begin
        state_nx = BUSY;
      end
      BUSY: begin
        if (draw_done) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    launch = 1'b0;
    busy   = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
      end
      LAUNCH: begin
        launch = 1'b1;
      end
      BUSY: begin
        launch = 1'b0;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign draw_go = launch;

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      sta_x    <= '0;
      sta_y    <= '0;
      end_x    <= '0;
      end_y    <= '0;
      cmd_beam <= '0;
      cmd_mode <= '0;
    end else if (host.write) begin
      unique case (host.address)
        A_STAX: sta_x    <= host.write_data;
        A_STAY: sta_y    <= host.write_data;
        A_ENDX: end_x    <= host.write_data;
        A_ENDY: end_y    <= host.write_data;
        A_BEAM: cmd_beam <= host.write_data[BEAM_W-1:0];
        A_MODE: cmd_mode <= host.write_data[1:0];
        A_BUSY: ;
        A_PRNG: ;
        default: ;
      endcase
    end
  end

  // Commit on entry to LAUNCH so cmd_* are stable while draw_go is high.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      cmd_sta_x <= '0;
      cmd_sta_y <= '0;
      cmd_end_x <= '0;
      cmd_end_y <= '0;
    end else if ((state == IDLE) && go_wr) begin
      cmd_sta_x <= sta_x;
      cmd_sta_y <= sta_y;
      cmd_end_x <= end_x;
      cmd_end_y <= end_y;
    end
  end

  // Zero is a lock-up state of the LFSR, so it is replaced by the seed.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      prng <= PRNG_SEED;
    end else if (prng_wr) begin
      if (host.write_data == 8'h00) begin
        prng <= PRNG_SEED;
      end else begin
        prng <= host.write_data;
      end
    end else begin
      prng <= prng_nx;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (host.address)
      A_STAX: rd_mux = sta_x;
      A_STAY: rd_mux = sta_y;
      A_ENDX: rd_mux = end_x;
      A_ENDY: rd_mux = end_y;
      A_BUSY: rd_mux = {7'b0, busy};
      A_BEAM: rd_mux[BEAM_W-1:0] = cmd_beam;
      A_MODE: rd_mux[1:0] = cmd_mode;
      A_PRNG: rd_mux = prng;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      host.read_data <= '0;
    end else begin
      host.read_data <= rd_mux;
    end
  end

  // vblnk_q tracks vblnk during reset so a level already high
  // at release is not seen as a rising edge.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vblnk_q  <= vblnk;
      host.irq <= 1'b0;
    end else begin
      vblnk_q  <= vblnk;
      host.irq <= vblnk & ~vblnk_q;
    end
  end

endmodule

// File: tb/tb_vga_host_regs.sv
// Bench for vga_host_regs: register table, directed GO/BUSY/irq/reset
// sequences, then random traffic against a register-file reference model.
module tb_vga_host_regs;

  localparam logic [7:0] SEED = 8'h01;
  localparam int         BW   = 4;

  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vblnk = 1'b0;
  logic          draw_done = 1'b0;
  logic          draw_go;
  logic [7:0]    csx;
  logic [7:0]    csy;
  logic [7:0]    cex;
  logic [7:0]    cey;
  logic [BW-1:0] cbeam;
  logic [1:0]    cmode;

  vga_host_regs_if bus();

  always #5 pclk = ~pclk;

  vga_host_regs #(
    .PRNG_SEED(SEED),
    .BEAM_W(BW)
  ) dut (
    .pclk(pclk),
    .rst_n(rst_n),
    .host(bus),
    .vblnk(vblnk),
    .draw_done(draw_done),
    .draw_go(draw_go),
    .cmd_sta_x(csx),
    .cmd_sta_y(csy),
    .cmd_end_x(cex),
    .cmd_end_y(cey),
    .cmd_beam(cbeam),
    .cmd_mode(cmode)
  );

  int total = 0;
  int bad   = 0;
  int n_go  = 0;
  int n_irq = 0;

  // reference model: register file + busy/launch flags
  logic [7:0] m_reg [8];
  logic [7:0] m_cmd [4];
  logic [7:0] m_prng;
  logic [7:0] m_rd;
  logic       m_busy;
  logic       m_launch;
  logic       m_irq;
  logic       m_vb;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [2:0] a;
    logic [7:0] d;
    a = bus.address;
    d = bus.write_data;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
      for (int i = 0; i < 4; i++) m_cmd[i] = 8'h00;
      m_prng   = SEED;
      m_busy   = 1'b0;
      m_launch = 1'b0;
      m_rd     = 8'h00;
      m_irq    = 1'b0;
      m_vb     = vblnk;
      return;
    end
    if (a == 3'd4)      m_rd = {7'b0, m_busy};
    else if (a == 3'd7) m_rd = m_prng;
    else                m_rd = m_reg[a];
    m_irq = vblnk && !m_vb;
    m_vb  = vblnk;
    if (m_launch) begin
      m_launch = 1'b0;
    end else if (m_busy) begin
      if (draw_done) m_busy = 1'b0;
    end else if (bus.write && a == 3'd4 && d[0]) begin
      m_busy   = 1'b1;
      m_launch = 1'b1;
      for (int i = 0; i < 4; i++) m_cmd[i] = m_reg[i];
    end
    if (bus.write && a <= 3'd3) m_reg[a] = d;
    if (bus.write && a == 3'd5) m_reg[5] = d % (1 << BW);
    if (bus.write && a == 3'd6) m_reg[6] = d % 4;
    if (bus.write && a == 3'd7)
      m_prng = (d == 8'h00) ? SEED : d;
    else
      m_prng = {m_prng[6:0],
                m_prng[7] ^ m_prng[5] ^ m_prng[4] ^ m_prng[3]};
  endtask

  task automatic cyc(input logic [2:0] a,
                     input logic       w,
                     input logic [7:0] d,
                     input logic       vb,
                     input logic       dd);
    bus.address    = a;
    bus.write      = w;
    bus.write_data = d;
    vblnk          = vb;
    draw_done      = dd;
    @(posedge pclk);
    model_edge();
    #1;
    chk("read_data", bus.read_data, m_rd);
    chk("irq", bus.irq, m_irq);
    chk("draw_go", draw_go, m_launch);
    chk("cmd_sta_x", csx, m_cmd[0]);
    chk("cmd_sta_y", csy, m_cmd[1]);
    chk("cmd_end_x", cex, m_cmd[2]);
    chk("cmd_end_y", cey, m_cmd[3]);
    chk("cmd_beam", cbeam, m_reg[5]);
    chk("cmd_mode", cmode, m_reg[6]);
    if (draw_go) n_go++;
    if (bus.irq) n_irq++;
  endtask

  initial begin
    int g0;
    int i0;
    logic vb;

    tbl[0] = '{3'd0, 8'd128, 8'd128, "rd_stax"};
    tbl[1] = '{3'd1, 8'd126, 8'd126, "rd_stay"};
    tbl[2] = '{3'd2, 8'd128, 8'd128, "rd_endx"};
    tbl[3] = '{3'd3, 8'd100, 8'd100, "rd_endy"};
    tbl[4] = '{3'd5, 8'hFF, 8'h0F, "rd_beam_mask"};
    tbl[5] = '{3'd6, 8'h07, 8'h03, "rd_mode_mask"};
    tbl[6] = '{3'd7, 8'h00, 8'h01, "rd_prng_zero"};
    tbl[7] = '{3'd7, 8'h5A, 8'h5A, "rd_prng_load"};
    tbl[8] = '{3'd4, 8'h00, 8'h00, "rd_busy_nogo"};
    tbl[9] = '{3'd5, 8'hA3, 8'h03, "rd_beam_hi"};

    bus.address    = 3'd7;
    bus.write      = 1'b0;
    bus.write_data = 8'h00;

    // reset and PRNG sequence from seed
    rst_n = 1'b0;
    repeat (3) cyc(3'd7, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_read", bus.read_data, 8'h00);
    chk("rst_irq", bus.irq, 1'b0);
    chk("rst_go", draw_go, 1'b0);
    rst_n = 1'b1;
    cyc(3'd7, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("prng0", bus.read_data, 8'h01);
    cyc(3'd7, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("prng1", bus.read_data, 8'h02);
    cyc(3'd7, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("prng2", bus.read_data, 8'h04);

    // register table
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].a, 1'b1, tbl[i].d, 1'b0, 1'b0);
      cyc(tbl[i].a, 1'b0, 8'h00, 1'b0, 1'b0);
      chk(tbl[i].nm, bus.read_data, tbl[i].exp);
    end

    cyc(3'd5, 1'b1, 8'hFF, 1'b0, 1'b0);
    cyc(3'd6, 1'b1, 8'h07, 1'b0, 1'b0);
    cyc(3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("beam_out", cbeam, 4'hF);
    chk("mode_out", cmode, 2'd3);

    // GO, busy until done
    g0 = n_go;
    cyc(3'd4, 1'b1, 8'h01, 1'b0, 1'b0);
    chk("go_pulse", draw_go, 1'b1);
    cyc(3'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("go_single", draw_go, 1'b0);
    chk("busy_rd", bus.read_data, 8'h01);
    chk("cmd_sx", csx, 8'd128);
    chk("cmd_sy", csy, 8'd126);
    chk("cmd_ex", cex, 8'd128);
    chk("cmd_ey", cey, 8'd100);
    repeat (5) cyc(3'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("busy_hold", bus.read_data, 8'h01);
    cyc(3'd4, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("busy_at_done", bus.read_data, 8'h01);
    cyc(3'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("busy_clear", bus.read_data, 8'h00);
    chk("go_count1", n_go - g0, 1);

    // no requeue while busy; shadow commits on next GO
    g0 = n_go;
    cyc(3'd4, 1'b1, 8'h01, 1'b0, 1'b0);
    cyc(3'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(3'd0, 1'b1, 8'd200, 1'b0, 1'b0);
    cyc(3'd4, 1'b1, 8'h01, 1'b0, 1'b0);
    repeat (3) cyc(3'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("no_requeue", n_go - g0, 1);
    chk("sx_kept", csx, 8'd128);
    cyc(3'd4, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc(3'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(3'd4, 1'b1, 8'h01, 1'b0, 1'b0);
    cyc(3'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("sx_new", csx, 8'd200);
    chk("go_count2", n_go - g0, 2);

    // GO on same edge as done while busy is dropped
    g0 = n_go;
    cyc(3'd4, 1'b1, 8'h01, 1'b0, 1'b1);
    cyc(3'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("same_edge_idle", bus.read_data, 8'h00);
    cyc(3'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("same_edge_go", n_go - g0, 0);

    // vblank irq: one pulse per rising edge
    i0 = n_irq;
    cyc(3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("irq_rise", bus.irq, 1'b1);
    cyc(3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("irq_one", bus.irq, 1'b0);
    repeat (1000) cyc(3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("irq_hold", n_irq - i0, 1);

    // reset during busy, vblnk high across reset
    cyc(3'd4, 1'b1, 8'h01, 1'b1, 1'b0);
    cyc(3'd4, 1'b0, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b0;
    g0 = n_go;
    i0 = n_irq;
    cyc(3'd4, 1'b0, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b1;
    cyc(3'd4, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("rst_busy0", bus.read_data, 8'h00);
    cyc(3'd4, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("rst_busy1", bus.read_data, 8'h00);
    chk("rst_no_go", n_go - g0, 0);
    chk("rst_no_irq", n_irq - i0, 0);
    cyc(3'd7, 1'b0, 8'h00, 1'b0, 1'b0);

    // random traffic against the model
    vb = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 29) == 0) vb = ~vb;
      cyc(3'($urandom_range(0, 7)),
          ($urandom_range(0, 2) == 0),
          8'($urandom),
          vb,
          ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
